// File: rtl/spi_adc_pkg.sv
// Shared types for the MCP3002-style SPI ADC responder: FSM states and the
// decoded per-frame configuration word.
package spi_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        NULL,
        DATA_MSB,
        DATA_LSB,
        TAIL
    } spi_adc_state_t;

    typedef struct packed {
        logic sgl;
        logic odd;
        logic msbf;
    } cfg_t;

    localparam int CFG_W = $bits(cfg_t);

endpackage

// File: rtl/spi_adc_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus rise/fall pulses
// taken from the synchronized level and one extra history register.
module sync_edge
    import spi_adc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// Emulated 2-channel MCP3002-style ADC: oversamples the SPI pins on CLOCK_50,
// decodes start/SGL/ODD/MSBF, latches the sample and shifts it out on MISO.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                SCLK,
    input  logic                CS,
    input  logic                MOSI,
    output logic                MISO,
    output logic                MISO_OE,
    input  logic [DATA_W-1:0]   ch0_data,
    input  logic [DATA_W-1:0]   ch1_data,
    output logic                frame_done,
    output logic [CFG_W-1:0]    last_cfg,
    output spi_adc_state_t      dbg_state
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Handshake-free link: the master owns SCLK/CS/MOSI timing; this block
    // only reacts to synchronized edges and never back-pressures.
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .din   (SCLK),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .din   (CS),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .din   (MOSI),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_adc_state_t     state_q;
    logic [CNT_W-1:0]   cnt_q;
    cfg_t               cfg_q;
    cfg_t               last_cfg_q;
    logic [DATA_W-1:0]  data_q;

    // Differential result is formed one bit wider so the borrow flags a clamp.
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  sample_val;

    always_comb begin
        diff       = '0;
        sample_val = '0;
        if (cfg_q.odd)
            diff = {1'b0, ch1_data} - {1'b0, ch0_data};
        else
            diff = {1'b0, ch0_data} - {1'b0, ch1_data};
        if (cfg_q.sgl)
            sample_val = cfg_q.odd ? ch1_data : ch0_data;
        else if (diff[DATA_W])
            sample_val = '0;
        else
            sample_val = diff[DATA_W-1:0];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cfg_q      <= '0;
            last_cfg_q <= '0;
            data_q     <= '0;
            MISO       <= 1'b0;
            MISO_OE    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cs_rise && state_q != IDLE) begin
                // CS release beats any SCLK edge seen in the same cycle.
                state_q <= IDLE;
                cnt_q   <= '0;
                MISO    <= 1'b0;
                MISO_OE <= 1'b0;
                if (state_q == TAIL) begin
                    frame_done <= 1'b1;
                    last_cfg_q <= cfg_q;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        MISO    <= 1'b0;
                        MISO_OE <= 1'b0;
                        if (cs_fall) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            MISO_OE <= 1'b1;
                        end
                    end
                    START: begin
                        if (sclk_rise && mosi_s) begin
                            state_q <= CMD;
                            cnt_q   <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cnt_q <= cnt_q + CNT_ONE;
                            if (cnt_q == CNT_W'(0)) begin
                                cfg_q.sgl <= mosi_s;
                            end else if (cnt_q == CNT_W'(1)) begin
                                cfg_q.odd <= mosi_s;
                            end else begin
                                // Sample instant: channel data is frozen here.
                                cfg_q.msbf <= mosi_s;
                                data_q     <= sample_val;
                                state_q    <= NULL;
                                cnt_q      <= '0;
                            end
                        end
                    end
                    NULL: begin
                        if (sclk_fall) begin
                            MISO    <= 1'b0;
                            state_q <= DATA_MSB;
                            cnt_q   <= '0;
                        end
                    end
                    DATA_MSB: begin
                        if (sclk_fall) begin
                            // Rotate so the word is intact again for the LSB pass.
                            MISO   <= data_q[DATA_W-1];
                            data_q <= {data_q[DATA_W-2:0], data_q[DATA_W-1]};
                            cnt_q  <= cnt_q + CNT_ONE;
                            if (cnt_q == CNT_W'(DATA_W-1)) begin
                                state_q <= cfg_q.msbf ? TAIL : DATA_LSB;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    DATA_LSB: begin
                        if (sclk_fall) begin
                            MISO   <= data_q[1];
                            data_q <= {data_q[0], data_q[DATA_W-1:1]};
                            cnt_q  <= cnt_q + CNT_ONE;
                            if (cnt_q == CNT_W'(DATA_W-2)) begin
                                state_q <= TAIL;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    TAIL: begin
                        if (sclk_fall)
                            MISO <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        MISO    <= 1'b0;
                        MISO_OE <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign last_cfg  = last_cfg_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a bit-level SPI master, a frame
// model built from the ADC's command rules, and an event-driven MISO checker.
module tb_spi_adc_responder;
    import spi_adc_pkg::*;

    localparam int W = 10;

    logic           CLOCK_50 = 1'b0;
    logic           RESET_N;
    logic           SCLK;
    logic           CS;
    logic           MOSI;
    logic           MISO;
    logic           MISO_OE;
    logic [W-1:0]   ch0_data;
    logic [W-1:0]   ch1_data;
    logic           frame_done;
    logic [2:0]     last_cfg;
    spi_adc_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_count = 0;

    logic [1:0] exp_q[$];
    logic       rx_q[$];
    logic [2:0] model_cfg = 3'b000;
    event       sample_ev;

    spi_adc_responder #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .SCLK       (SCLK),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .MISO_OE    (MISO_OE),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .frame_done (frame_done),
        .last_cfg   (last_cfg),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time budget, got timeout, required finish");
        $fatal(1);
    end

    always @(negedge CLOCK_50)
        if (frame_done === 1'b1) fd_count++;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Entries are {miso_oe, miso} required a half SCLK after each fall.
    always @(sample_ev) begin
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sample_underflow: got unexpected sample miso=%0b, required none", MISO);
        end else begin
            e = exp_q.pop_front();
            check("miso", {31'b0, MISO}, {31'b0, e[0]});
            check("miso_oe", {31'b0, MISO_OE}, {31'b0, e[1]});
        end
        rx_q.push_back(MISO);
    end

    function automatic logic [W-1:0] model_data(input logic s, input logic o,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        if (s) return o ? b : a;
        d = o ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        if (d < 0) d = 0;
        return W'(d);
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // One 1 MHz SCLK period: MOSI set up well before the rise, MISO sampled mid-low.
    task automatic spi_clock(input logic b);
        MOSI = b;
        wait_cyc(12);
        SCLK = 1'b1;
        wait_cyc(25);
        SCLK = 1'b0;
        wait_cyc(12);
        -> sample_ev;
        wait_cyc(1);
    endtask

    task automatic run_frame(input int lead, input logic s, input logic o, input logic m,
                             input int abort_bits, input bit do_chg, input logic [W-1:0] chg_val,
                             output logic [W-1:0] word);
        logic [W-1:0] d;
        logic         cmd_bits[$];
        int           n_clk;
        int           fd_before;
        bit           full;
        full = (abort_bits < 0);
        d = model_data(s, o, ch0_data, ch1_data);
        for (int i = 0; i < lead; i++) cmd_bits.push_back(1'b0);
        cmd_bits.push_back(1'b1);
        cmd_bits.push_back(s);
        cmd_bits.push_back(o);
        cmd_bits.push_back(m);
        exp_q.delete();
        rx_q.delete();
        for (int i = 0; i < lead + 4; i++) exp_q.push_back(2'b10);
        for (int k = W - 1; k >= 0; k--) exp_q.push_back({1'b1, d[k]});
        if (!m) for (int k = 1; k < W; k++) exp_q.push_back({1'b1, d[k]});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b10);
        if (!full) while (exp_q.size() > lead + 4 + abort_bits) void'(exp_q.pop_back());
        n_clk = exp_q.size();

        CS = 1'b0;
        wait_cyc(10);
        for (int i = 0; i < n_clk; i++) begin
            if (i < lead + 4) spi_clock(cmd_bits[i]);
            else spi_clock(1'b0);
            if (do_chg && i == lead + 4) ch0_data = chg_val;
        end
        check("exp_q_drained", exp_q.size(), 0);
        word = '0;
        if (full) for (int k = 0; k < W; k++) word[W-1-k] = rx_q[lead + 4 + k];

        wait_cyc(5);
        fd_before = fd_count;
        CS = 1'b1;
        wait_cyc(3);
        check("frame_done_at_cs_rise", {31'b0, frame_done}, {31'b0, full});
        check("miso_oe_after_cs_rise", {31'b0, MISO_OE}, 32'd0);
        check("miso_after_cs_rise", {31'b0, MISO}, 32'd0);
        wait_cyc(10);
        check("frame_done_count", fd_count - fd_before, {31'b0, full});
        if (full) model_cfg = {s, o, m};
        check("last_cfg", {29'b0, last_cfg}, {29'b0, model_cfg});
        check("state_idle", dbg_state, IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] word;
        logic         acc;
        RESET_N  = 1'b0;
        SCLK     = 1'b0;
        CS       = 1'b1;
        MOSI     = 1'b0;
        ch0_data = '0;
        ch1_data = '0;
        wait_cyc(5);
        check("rst_miso", {31'b0, MISO}, 32'd0);
        check("rst_miso_oe", {31'b0, MISO_OE}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_last_cfg", {29'b0, last_cfg}, 32'd0);
        check("rst_state", dbg_state, IDLE);
        RESET_N = 1'b1;
        wait_cyc(10);

        // Single-ended ch0, MSB first.
        ch0_data = 10'h2A5;
        ch1_data = 10'h155;
        run_frame(0, 1'b1, 1'b0, 1'b1, -1, 1'b0, '0, word);
        check("t1_word", {22'b0, word}, 32'h2A5);
        check("t1_last_cfg", {29'b0, last_cfg}, 32'b101);

        // Single-ended ch1 with LSB-first tail.
        ch1_data = 10'h001;
        run_frame(0, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0, word);
        check("t2_word", {22'b0, word}, 32'h001);
        acc = 1'b0;
        for (int i = 14; i < 25; i++) acc = acc | rx_q[i];
        check("t2_lsb_tail_zero", {31'b0, acc}, 32'd0);
        check("t2_last_cfg", {29'b0, last_cfg}, 32'b110);

        // Differential, clamped and unclamped.
        ch0_data = 10'h100;
        ch1_data = 10'h180;
        run_frame(0, 1'b0, 1'b0, 1'b1, -1, 1'b0, '0, word);
        check("t3_diff_clamp", {22'b0, word}, 32'h000);
        check("t3_last_cfg", {29'b0, last_cfg}, 32'b001);
        run_frame(0, 1'b0, 1'b1, 1'b1, -1, 1'b0, '0, word);
        check("t3_diff_odd", {22'b0, word}, 32'h080);
        check("t3b_last_cfg", {29'b0, last_cfg}, 32'b011);

        // Leading zeros and channel change after the sample instant.
        ch0_data = 10'h3FF;
        run_frame(3, 1'b1, 1'b0, 1'b1, -1, 1'b1, 10'h000, word);
        check("t4_word_held", {22'b0, word}, 32'h3FF);
        check("t4_last_cfg", {29'b0, last_cfg}, 32'b101);

        // Abort after 5 data bits, then a clean frame.
        ch0_data = 10'h2A5;
        run_frame(0, 1'b0, 1'b1, 1'b0, 5, 1'b0, '0, word);
        check("t5_last_cfg_kept", {29'b0, last_cfg}, 32'b101);
        ch0_data = 10'h050;
        ch1_data = 10'h3C0;
        run_frame(0, 1'b0, 1'b1, 1'b1, -1, 1'b0, '0, word);
        check("t5_word_after_abort", {22'b0, word}, 32'h370);
        check("t5b_last_cfg", {29'b0, last_cfg}, 32'b011);

        // Reset during DATA_MSB, released with CS still low.
        ch0_data = 10'h2A5;
        exp_q.delete();
        rx_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        CS = 1'b0;
        wait_cyc(10);
        spi_clock(1'b1);
        spi_clock(1'b1);
        spi_clock(1'b0);
        spi_clock(1'b1);
        spi_clock(1'b0);
        spi_clock(1'b0);
        spi_clock(1'b0);
        check("t6_in_data_msb", dbg_state, DATA_MSB);
        RESET_N = 1'b0;
        #1;
        check("t6_rst_miso", {31'b0, MISO}, 32'd0);
        check("t6_rst_miso_oe", {31'b0, MISO_OE}, 32'd0);
        check("t6_rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("t6_rst_last_cfg", {29'b0, last_cfg}, 32'd0);
        check("t6_rst_state", dbg_state, IDLE);
        model_cfg = 3'b000;
        wait_cyc(5);
        RESET_N = 1'b1;
        wait_cyc(10);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'b00);
        spi_clock(1'b1);
        spi_clock(1'b1);
        spi_clock(1'b0);
        spi_clock(1'b1);
        for (int i = 0; i < 4; i++) spi_clock(1'b0);
        check("t6_ignored_state", dbg_state, IDLE);
        check("t6_ignored_drained", exp_q.size(), 0);
        CS = 1'b1;
        wait_cyc(10);
        ch0_data = 10'h1C3;
        run_frame(0, 1'b1, 1'b0, 1'b1, -1, 1'b0, '0, word);
        check("t6_word_after_reset", {22'b0, word}, 32'h1C3);
        check("t6_last_cfg", {29'b0, last_cfg}, 32'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
